// File: rtl/bus_arbiter.sv
// Round-robin arbiter for a shared tri-state bus: registered grant, driver enable
// delayed one settle cycle, and a one-cycle turnaround gap between owners.
module bus_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic [N-1:0]         drv_en,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy
);
  localparam int OW = $clog2(N);
  localparam int HW = 8;

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t         state, state_n;
  logic [N-1:0]   grant_n, drv_n;
  logic [OW-1:0]  owner_n, last, last_n, win_idx;
  logic [HW-1:0]  hold, hold_n;
  logic           win_found, others, hold_max;

  // First requester above the last releasing owner, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 1; i <= N; i++) begin
      if (!win_found && req[OW'((int'(last) + i) % N)]) begin
        win_found = 1'b1;
        win_idx   = OW'((int'(last) + i) % N);
      end
    end
  end

  assign others   = |(req & ~(N'(1) << owner));
  assign hold_max = (hold == HW'(MAX_HOLD - 1));

  always_comb begin
    state_n = state;
    grant_n = grant;
    drv_n   = drv_en;
    owner_n = owner;
    hold_n  = hold;
    last_n  = last;
    case (state)
      IDLE, TURN: begin
        grant_n = '0;
        drv_n   = '0;
        state_n = IDLE;
        if (win_found) begin
          state_n = GRANT;
          grant_n = N'(1) << win_idx;
          owner_n = win_idx;
          hold_n  = '0;
        end
      end
      GRANT: begin
        if (!req[owner] || (hold_max && others)) begin
          state_n = TURN;
          grant_n = '0;
          drv_n   = '0;
          last_n  = owner;
        end else begin
          // driver enable follows grant after one settle cycle
          drv_n = grant;
          if (!hold_max) hold_n = hold + HW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        drv_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      grant  <= '0;
      drv_en <= '0;
      owner  <= '0;
      hold   <= '0;
      last   <= OW'(N - 1);
    end else begin
      state  <= state_n;
      grant  <= grant_n;
      drv_en <= drv_n;
      owner  <= owner_n;
      hold   <= hold_n;
      last   <= last_n;
    end
  end

  assign busy = |grant;

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized scoreboard bench for bus_arbiter: a cycle-level reference model pushes
// expected outputs per edge, a monitor pops and compares, plus per-cycle invariants.
module tb_bus_arbiter;
  localparam int N        = 4;
  localparam int MAX_HOLD = 8;
  localparam int BOUND    = (N - 1) * (MAX_HOLD + 1) + 1;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic [N-1:0] req   = '0;
  logic [N-1:0] grant, drv_en;
  logic [1:0]   owner;
  logic         busy;

  bus_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .grant(grant), .drv_en(drv_en), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] grant;
    logic [N-1:0] drv;
    logic [1:0]   owner;
    logic         busy;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0, miscompares = 0;

  // Reference model: who holds the bus and for how many cycles it has been visible.
  int m_own  = -1;
  int m_held = 0;
  int m_last = N - 1;
  int m_disp = 0;
  int wait_cnt[N];
  int max_wait = 0;

  function automatic bit bitof(logic [N-1:0] v, int p);
    return ((v >> p) & N'(1)) != '0;
  endfunction

  function automatic int rr_winner(logic [N-1:0] v, int last);
    for (int k = 1; k <= N; k++)
      if (bitof(v, (last + k) % N)) return (last + k) % N;
    return -1;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model(logic r, logic [N-1:0] v);
    exp_t e;
    bit   oth;
    int   w;
    if (!r) begin
      m_own = -1; m_held = 0; m_last = N - 1; m_disp = 0;
    end else if (m_own >= 0) begin
      oth = 1'b0;
      for (int k = 0; k < N; k++) if (k != m_own && bitof(v, k)) oth = 1'b1;
      if (!bitof(v, m_own) || (m_held >= MAX_HOLD && oth)) begin
        m_last = m_own;
        m_own  = -1;
      end else if (m_held < 100000) begin
        m_held++;
      end
    end else begin
      w = rr_winner(v, m_last);
      if (w >= 0) begin
        m_own = w; m_held = 1; m_disp = w;
      end
    end
    e.grant = (m_own >= 0) ? (N'(1) << m_own) : '0;
    e.drv   = (m_own >= 0 && m_held >= 2) ? e.grant : '0;
    e.owner = 2'(m_disp);
    e.busy  = (m_own >= 0);
    exp_q.push_back(e);
  endtask

  task automatic step(logic r, logic [N-1:0] v);
    @(negedge clk);
    rst_n = r;
    req   = v;
    model(r, v);
  endtask

  // A pulse on req between edges must not be seen; only v is sampled.
  task automatic step_glitch(logic [N-1:0] g, logic [N-1:0] v);
    @(negedge clk);
    req = g;
    #2;
    req = v;
    model(1'b1, v);
  endtask

  // Monitor: compare against the scoreboard and check invariants every edge.
  initial begin
    exp_t         e;
    logic [N-1:0] prev_grant = '0, prev_drv = '0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("grant", 32'(grant), 32'(e.grant));
        chk("drv_en", 32'(drv_en), 32'(e.drv));
        chk("owner", 32'(owner), 32'(e.owner));
        chk("busy", 32'(busy), 32'(e.busy));
      end
      chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
      chk("drv_onehot0", 32'($onehot0(drv_en)), 32'd1);
      chk("busy_or", 32'(busy), 32'(|grant));
      chk("turnaround", 32'(prev_drv != '0 && drv_en != '0 && drv_en != prev_drv), 32'd0);
      chk("grant_gap", 32'(prev_grant != '0 && grant != '0 && grant != prev_grant), 32'd0);
      prev_grant = grant;
      prev_drv   = drv_en;
      for (int i = 0; i < N; i++) begin
        if (rst_n && bitof(req, i) && !bitof(grant, i)) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
      end
    end
  end

  initial begin
    logic [N-1:0] cur = '0, flip;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_drv", 32'(drv_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    step(1'b0, '0);

    // Two requesters, then owner 1 releases and 2 takes over after TURN.
    repeat (4) step(1'b1, 4'b0110);
    repeat (4) step(1'b1, 4'b0100);
    repeat (2) step(1'b1, 4'b0000);

    // Full contention: rotation with MAX_HOLD cycles each.
    repeat (45) step(1'b1, 4'b1111);
    repeat (2) step(1'b1, 4'b0000);

    // Single requester keeps the bus indefinitely.
    repeat (100) step(1'b1, 4'b0100);
    repeat (2) step(1'b1, 4'b0000);

    // Sub-cycle pulses are ignored.
    repeat (4) step_glitch(4'b1011, 4'b0000);

    // Asynchronous reset while requester 3 holds the bus.
    repeat (3) step(1'b1, 4'b1000);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_grant", 32'(grant), 32'd0);
    chk("async_drv", 32'(drv_en), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    step(1'b0, 4'b1001);
    repeat (4) step(1'b1, 4'b1001);
    repeat (2) step(1'b1, 4'b0000);

    // Random sticky requests so holds can reach the limit.
    repeat (10000) begin
      flip = '0;
      for (int b = 0; b < N; b++)
        if ($urandom_range(5) == 0) flip = flip | (N'(1) << b);
      cur = cur ^ flip;
      step(1'b1, cur);
    end

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("max_wait_ok", 32'(max_wait <= BOUND), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: N, 4, number of requesters sharing the tri-state bus (2..8).
REQ-002 Parameter: MAX_HOLD, 8, max consecutive grant cycles while another requester waits (2..255).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: req  input  N  per-requester bus request, level-sensitive.
REQ-006 Port: grant  output  N  registered one-hot-or-zero grant.
REQ-007 Port: drv_en  output  N  registered one-hot-or-zero tri-state driver enable, feeding the E pins of the bus driver cells.
REQ-008 Port: owner  output  clog2(N)  index of current grant holder; holds last value when grant is zero.
REQ-009 Port: busy  output  1  high whenever grant is nonzero.

Function
REQ-010 FSM states SHALL be IDLE, GRANT and TURN; encoding is free.
REQ-011 IDLE: grant=0 and drv_en=0; if any req bit is high at an edge, move to GRANT and set grant to the round-robin winner on that edge.
REQ-012 Round-robin winner SHALL be the first set req bit searching upward from (last+1) mod N with wrap-around, where last is the most recent releasing owner.
REQ-013 Request-to-grant latency SHALL be exactly one edge from IDLE and exactly one edge after the TURN cycle.
REQ-014 drv_en[i] SHALL assert one cycle after grant[i] asserts (driver settle cycle) and remain high while grant[i] is high.
REQ-015 grant and drv_en SHALL deassert on the same edge when a grant is released.
REQ-016 GRANT: hold counter SHALL reset to 0 on grant and increment each granted cycle, saturating at MAX_HOLD-1.
REQ-017 GRANT exits to TURN on the edge where req[owner] is low, or where the hold counter equals MAX_HOLD-1 and any other req bit is high.
REQ-018 Without competing requests, the holder keeps the grant indefinitely (no forced release).
REQ-019 On GRANT->TURN, last SHALL update to owner.
REQ-020 TURN SHALL last exactly one cycle with grant=0 and drv_en=0 (bus turnaround; no two drivers enabled in adjacent cycles).
REQ-021 From TURN: any req high goes to GRANT with the round-robin winner; otherwise go to IDLE.
REQ-022 A releasing requester that still asserts req SHALL be eligible from TURN but only after all higher-rotation requesters.
REQ-023 Simultaneous requests SHALL be resolved solely by REQ-012; ties are impossible.
REQ-024 req pulses that start and end between edges SHALL be ignored; only edge-sampled values count.
REQ-025 At most one grant bit and at most one drv_en bit SHALL be high in any cycle.
REQ-026 busy SHALL equal the OR of the grant bits.

Reset
REQ-027 While rst_n is low: grant=0, drv_en=0, busy=0, owner=0, hold counter=0, FSM=IDLE, last=N-1 (requester 0 wins first).
REQ-028 Reset assertion mid-grant SHALL drop drv_en and grant immediately, without waiting for a clock edge.
REQ-029 The first edge after rst_n rises SHALL evaluate req normally from IDLE.

Verification
REQ-030 Reset then req=4'b0110 held -> grant=0010 at edge 1, drv_en=0010 at edge 2; release req[1] -> TURN cycle, then grant=0100.
REQ-031 req=4'b1111 held, MAX_HOLD=8 -> grants rotate 0001,0010,0100,1000,0001; each lasts 8 cycles, separated by exactly one all-zero cycle.
REQ-032 Only req[2] held for 100 cycles -> grant=0100 is continuous and drv_en=0100 from cycle 2 onward; no TURN occurs.
REQ-033 rst_n pulsed low mid-grant while grant=1000 -> grant and drv_en are 0 before the next edge; after release with req=1001, grant=0001.
REQ-034 Random req for 10k cycles -> assert REQ-020, REQ-025 and REQ-026 every cycle; no requester waits more than (N-1)*(MAX_HOLD+1)+1 cycles while holding req.
